xor_stim_checker: RTL and testbench

Self-checking stimulus stage that sits directly upstream and downstream of the XOR-concatenation compare block. It drives that block's 64-bit `x` input with a run of pseudo-random vectors and samples its `badness`/`goodness` flags on every vector. It counts failures, captures the first failing vector, and reports pass/fail when the run completes. Its purpose is to expose simulator mis-evaluation of the compare expressions in a cycle-accurate, regression-friendly way.

---
 rtl/xor_chk_pkg.sv | 15 +
 rtl/lfsr64.sv | 11 +
 rtl/xor_stim_checker.sv | 110 +++++++++++
 tb/tb_xor_stim_checker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/xor_chk_pkg.sv
// Shared types and constants for the XOR compare-block stimulus checker.
package xor_chk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Galois feedback for x^64+x^63+x^61+x^60+1, shifting right.
    localparam logic [63:0] LfsrMask = 64'hD800_0000_0000_0000;

    localparam int unsigned CntWidth = 16;

endpackage

// File: rtl/lfsr64.sv
// Combinational next-state function of a 64-bit right-shifting Galois LFSR.
module lfsr64 #(
    parameter logic [63:0] Mask = 64'hD800_0000_0000_0000
) (
    input  logic [63:0] state_i,
    output logic [63:0] state_o
);

    assign state_o = (state_i >> 1) ^ (state_i[0] ? Mask : 64'd0);

endmodule

// File: rtl/xor_stim_checker.sv
// Drives LFSR vectors into the XOR compare block, counts flagged vectors and
// reports pass/fail once a run of N_VECTORS samples completes.
module xor_stim_checker
    import xor_chk_pkg::*;
#(
    parameter int unsigned N_VECTORS = 1024,
    parameter logic [63:0] SEED      = 64'h0000_0000_0000_0001
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [63:0]         x,
    input  logic                badness,
    input  logic                goodness,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CntWidth-1:0] bad_count,
    output logic [CntWidth-1:0] good_count,
    output logic [63:0]         first_fail_x,
    output logic                first_fail_valid
);

    localparam logic [63:0]         SeedEff = (SEED == 64'd0) ? 64'd1 : SEED;
    localparam logic [15:0]         LastIdx = 16'(N_VECTORS - 1);
    localparam logic [CntWidth-1:0] CntMax  = '1;

    state_e              state_q;
    logic [63:0]         x_q;
    logic [63:0]         x_d;
    logic [15:0]         idx_q;
    logic [CntWidth-1:0] bad_q;
    logic [CntWidth-1:0] good_q;
    logic [63:0]         ff_x_q;
    logic                ff_valid_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;

    lfsr64 #(
        .Mask(LfsrMask)
    ) u_lfsr (
        .state_i(x_q),
        .state_o(x_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            x_q        <= '0;
            idx_q      <= '0;
            bad_q      <= '0;
            good_q     <= '0;
            ff_x_q     <= '0;
            ff_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q    <= StRun;
                        x_q        <= SeedEff;
                        idx_q      <= '0;
                        bad_q      <= '0;
                        good_q     <= '0;
                        ff_x_q     <= '0;
                        ff_valid_q <= 1'b0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                    end
                end
                StRun: begin
                    // The compare block is combinational: flags belong to x_q.
                    if (badness && bad_q != CntMax) begin
                        bad_q <= bad_q + 1'b1;
                    end
                    if (goodness && good_q != CntMax) begin
                        good_q <= good_q + 1'b1;
                    end
                    if ((badness || goodness) && !ff_valid_q) begin
                        ff_x_q     <= x_q;
                        ff_valid_q <= 1'b1;
                    end
                    x_q   <= x_d;
                    idx_q <= idx_q + 16'd1;
                    if (idx_q == LastIdx) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= !badness && !goodness && bad_q == '0 && good_q == '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign x                = x_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign bad_count        = bad_q;
    assign good_count       = good_q;
    assign first_fail_x     = ff_x_q;
    assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_xor_stim_checker.sv
// Directed self-checking bench: three checker instances with mocked compare flags.
module tb_xor_stim_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A: short run, seed 1.
    logic        start_a = 1'b0, bad_a = 1'b0, good_a = 1'b0;
    logic [63:0] x_a, ffx_a;
    logic        busy_a, done_a, pass_a, ffv_a;
    logic [15:0] badc_a, goodc_a;

    // Instance B: maximum-length run, both flags stuck high.
    logic        start_b = 1'b0, bad_b = 1'b0, good_b = 1'b0;
    logic [63:0] x_b, ffx_b;
    logic        busy_b, done_b, pass_b, ffv_b;
    logic [15:0] badc_b, goodc_b;

    // Instance C: zero seed.
    logic        start_c = 1'b0;
    logic [63:0] x_c, ffx_c;
    logic        busy_c, done_c, pass_c, ffv_c;
    logic [15:0] badc_c, goodc_c;

    localparam logic [63:0] SeedB = 64'h1234_5678_9ABC_DEF0;

    xor_stim_checker #(.N_VECTORS(16), .SEED(64'h1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .x(x_a),
        .badness(bad_a), .goodness(good_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .bad_count(badc_a), .good_count(goodc_a),
        .first_fail_x(ffx_a), .first_fail_valid(ffv_a)
    );

    xor_stim_checker #(.N_VECTORS(65535), .SEED(SeedB)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .x(x_b),
        .badness(bad_b), .goodness(good_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .bad_count(badc_b), .good_count(goodc_b),
        .first_fail_x(ffx_b), .first_fail_valid(ffv_b)
    );

    xor_stim_checker #(.N_VECTORS(4), .SEED(64'h0)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .x(x_c),
        .badness(1'b0), .goodness(1'b0), .busy(busy_c), .done(done_c),
        .pass(pass_c), .bad_count(badc_c), .good_count(goodc_c),
        .first_fail_x(ffx_c), .first_fail_valid(ffv_c)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] x_seen [3];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_a(input string pfx);
        check_eq({pfx, " x"}, x_a, 64'h0);
        check_eq({pfx, " busy"}, 64'(busy_a), 64'h0);
        check_eq({pfx, " done"}, 64'(done_a), 64'h0);
        check_eq({pfx, " pass"}, 64'(pass_a), 64'h0);
        check_eq({pfx, " bad_count"}, 64'(badc_a), 64'h0);
        check_eq({pfx, " good_count"}, 64'(goodc_a), 64'h0);
        check_eq({pfx, " first_fail_x"}, ffx_a, 64'h0);
        check_eq({pfx, " first_fail_valid"}, 64'(ffv_a), 64'h0);
    endtask

    // Pulses start on A, drives badness on vectors 5 and 9 when inject is set and
    // re-pulses start at RUN index restart_at; returns the number of RUN cycles.
    task automatic run_a(input bit inject, input int restart_at, output int ncyc);
        int idx = 0;
        bit fin = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 64 && !fin; c++) begin
            if (done_a) begin
                fin = 1'b1;
            end else begin
                if (busy_a) begin
                    if (idx < 3) x_seen[idx] = x_a;
                    bad_a   = inject && (idx == 5 || idx == 9);
                    start_a = (idx == restart_at);
                    idx++;
                end
                @(negedge clk);
            end
        end
        bad_a   = 1'b0;
        start_a = 1'b0;
        ncyc    = idx;
        if (!fin) check_eq("run_a timeout", 64'(done_a), 64'h1);
    endtask

    initial begin
        int ncyc;
        int cyc_b;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_a("reset");

        // Clean run and LFSR sequence.
        run_a(1'b0, -1, ncyc);
        check_eq("lfsr x0", x_seen[0], 64'h0000_0000_0000_0001);
        check_eq("lfsr x1", x_seen[1], 64'hD800_0000_0000_0000);
        check_eq("lfsr x2", x_seen[2], 64'h6C00_0000_0000_0000);
        check_eq("clean run length", 64'(ncyc), 64'd16);
        check_eq("clean pass", 64'(pass_a), 64'h1);
        check_eq("clean bad_count", 64'(badc_a), 64'h0);
        check_eq("clean good_count", 64'(goodc_a), 64'h0);
        check_eq("clean ffv", 64'(ffv_a), 64'h0);
        check_eq("clean busy", 64'(busy_a), 64'h0);

        // Flags outside RUN are ignored; results stay stable in DONE.
        bad_a  = 1'b1;
        good_a = 1'b1;
        repeat (3) @(negedge clk);
        bad_a  = 1'b0;
        good_a = 1'b0;
        check_eq("done hold done", 64'(done_a), 64'h1);
        check_eq("done hold pass", 64'(pass_a), 64'h1);
        check_eq("done hold bad_count", 64'(badc_a), 64'h0);

        // Restart from DONE with failures on vectors 5 and 9; start mid-run ignored.
        run_a(1'b1, 3, ncyc);
        check_eq("fail run length", 64'(ncyc), 64'd16);
        check_eq("fail restart x0", x_seen[0], 64'h1);
        check_eq("fail bad_count", 64'(badc_a), 64'd2);
        check_eq("fail good_count", 64'(goodc_a), 64'd0);
        check_eq("fail first_fail_x", ffx_a, 64'h0D80_0000_0000_0000);
        check_eq("fail ffv", 64'(ffv_a), 64'h1);
        check_eq("fail pass", 64'(pass_a), 64'h0);

        // Reset at RUN cycle 7 with partial results present.
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bad_a  = (i == 2);
            good_a = (i == 4);
            @(negedge clk);
        end
        bad_a  = 1'b0;
        good_a = 1'b0;
        check_eq("midrun bad_count before reset", 64'(badc_a), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_a("midrun reset");
        run_a(1'b0, -1, ncyc);
        check_eq("post reset run length", 64'(ncyc), 64'd16);
        check_eq("post reset pass", 64'(pass_a), 64'h1);
        check_eq("post reset x0", x_seen[0], 64'h1);

        // Zero seed is replaced by 1.
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        check_eq("seed0 busy", 64'(busy_c), 64'h1);
        check_eq("seed0 x0", x_c, 64'h1);

        // Both flags stuck high over the longest run.
        bad_b   = 1'b1;
        good_b  = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check_eq("sat x0", x_b, SeedB);
        cyc_b = 0;
        while (!done_b && cyc_b < 70000) begin
            cyc_b++;
            @(negedge clk);
        end
        check_eq("sat run length", 64'(cyc_b), 64'd65535);
        check_eq("sat bad_count", 64'(badc_b), 64'hFFFF);
        check_eq("sat good_count", 64'(goodc_b), 64'hFFFF);
        check_eq("sat first_fail_x", ffx_b, SeedB);
        check_eq("sat ffv", 64'(ffv_b), 64'h1);
        check_eq("sat pass", 64'(pass_b), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
